// File: rtl/zeroheti_obi_arb_if.sv
// rtl/zeroheti_obi_arb_if.sv - requester and subordinate signal bundle for the OBI arbiter
interface zeroheti_obi_arb_if #(
  parameter int NumReq = 3,
  parameter int IdxW   = $clog2(NumReq)
);
  logic [NumReq-1:0]       req_i;
  logic [NumReq-1:0][31:0] addr_i;
  logic [NumReq-1:0]       we_i;
  logic [NumReq-1:0][3:0]  be_i;
  logic [NumReq-1:0][31:0] wdata_i;
  logic [NumReq-1:0]       gnt_o;
  logic [NumReq-1:0]       rvalid_o;
  logic [31:0]             rdata_o;
  logic                    err_o;
  logic                    mgr_req_o;
  logic [31:0]             mgr_addr_o;
  logic                    mgr_we_o;
  logic [3:0]              mgr_be_o;
  logic [31:0]             mgr_wdata_o;
  logic                    mgr_gnt_i;
  logic                    mgr_rvalid_i;
  logic [31:0]             mgr_rdata_i;
  logic                    mgr_err_i;
  logic [IdxW-1:0]         owner_o;
  logic                    busy_o;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    input  mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o,
    output owner_o, busy_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    output mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o,
    input  owner_o, busy_o
  );
endinterface

// File: rtl/zeroheti_obi_arb.sv
// rtl/zeroheti_obi_arb.sv - round-robin N:1 OBI arbiter, one outstanding transaction
module zeroheti_obi_arb #(
  parameter int NumReq = 3,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  zeroheti_obi_arb_if.slave bus
);
  typedef enum logic {IDLE, OUTST} state_e;

  state_e          state_q;
  logic [IdxW-1:0] rr_q, owner_q, lk_idx_q, winner, rr_next;
  logic            lock_q, any_req, eligible, mgr_req, hshake;
  logic [IdxW:0]   cand;
  logic [NumReq-1:0] gnt, rvalid;

  // A locked (requested but ungranted) index keeps the payload stable until grant
  always_comb begin
    winner  = lk_idx_q;
    any_req = 1'b0;
    cand    = '0;
    if (lock_q) begin
      any_req = bus.req_i[lk_idx_q];
    end else begin
      winner = rr_q;
      for (int k = 0; k < NumReq; k++) begin
        cand = {1'b0, rr_q} + (IdxW+1)'(k);
        if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
        if (!any_req && bus.req_i[cand[IdxW-1:0]]) begin
          any_req = 1'b1;
          winner  = cand[IdxW-1:0];
        end
      end
    end
  end

  assign eligible = rst_ni && ((state_q == IDLE) || bus.mgr_rvalid_i);
  assign mgr_req  = eligible && any_req;
  assign hshake   = mgr_req && bus.mgr_gnt_i;
  assign rr_next  = (winner == IdxW'(NumReq-1)) ? '0 : winner + IdxW'(1);

  always_comb begin
    gnt    = '0;
    rvalid = '0;
    if (hshake) gnt[winner] = 1'b1;
    if (state_q == OUTST && bus.mgr_rvalid_i) rvalid[owner_q] = 1'b1;
  end

  assign bus.mgr_req_o   = mgr_req;
  assign bus.mgr_addr_o  = mgr_req ? bus.addr_i[winner]  : '0;
  assign bus.mgr_we_o    = mgr_req ? bus.we_i[winner]    : 1'b0;
  assign bus.mgr_be_o    = mgr_req ? bus.be_i[winner]    : '0;
  assign bus.mgr_wdata_o = mgr_req ? bus.wdata_i[winner] : '0;
  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rvalid;
  assign bus.rdata_o     = (state_q == OUTST) ? bus.mgr_rdata_i : '0;
  assign bus.err_o       = (state_q == OUTST) ? bus.mgr_err_i : 1'b0;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = (state_q == OUTST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      lock_q   <= 1'b0;
      lk_idx_q <= '0;
    end else if (hshake) begin
      state_q <= OUTST;
      owner_q <= winner;
      rr_q    <= rr_next;
      lock_q  <= 1'b0;
    end else begin
      if (mgr_req) begin
        lock_q   <= 1'b1;
        lk_idx_q <= winner;
      end else if (lock_q && !bus.req_i[lk_idx_q]) begin
        lock_q <= 1'b0;
      end
      if (state_q == OUTST && bus.mgr_rvalid_i) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// tb/tb_zeroheti_obi_arb.sv - vector, corner-case and randomized-model bench for zeroheti_obi_arb
module tb_zeroheti_obi_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  zeroheti_obi_arb_if #(.NumReq(3)) bus ();
  zeroheti_obi_arb #(.NumReq(3)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct {
    logic [2:0]  req;
    logic        gnt;
    logic        rv;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rv;
    logic        e_busy;
    logic [1:0]  e_owner;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [2:0] r, input logic g, input logic v);
    bus.req_i        = r;
    bus.mgr_gnt_i    = g;
    bus.mgr_rvalid_i = v;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: abstract busy flag, owner, pointer, pending lock
  int   m_owner, m_rr, m_lk, cnd;
  bit   m_busy, m_lock, m_any, m_elig, m_mreq;
  logic [2:0] e_gnt, e_rv;

  initial begin
    bus.req_i = '0; bus.we_i = '0; bus.be_i = '0; bus.wdata_i = '0;
    bus.mgr_gnt_i = 0; bus.mgr_rvalid_i = 0; bus.mgr_rdata_i = '0; bus.mgr_err_i = 0;
    for (int i = 0; i < 3; i++) bus.addr_i[i] = 32'h1000 + 32'(i * 16);
    rst_n = 1'b0;

    tbl[0] = '{3'b111, 1, 0, 1, 32'h1000, 3'b001, 3'b000, 0, 2'd0};
    tbl[1] = '{3'b111, 1, 1, 1, 32'h1010, 3'b010, 3'b001, 1, 2'd0};
    tbl[2] = '{3'b111, 1, 1, 1, 32'h1020, 3'b100, 3'b010, 1, 2'd1};
    tbl[3] = '{3'b111, 1, 1, 1, 32'h1000, 3'b001, 3'b100, 1, 2'd2};
    tbl[4] = '{3'b111, 1, 1, 1, 32'h1010, 3'b010, 3'b001, 1, 2'd0};
    tbl[5] = '{3'b111, 1, 1, 1, 32'h1020, 3'b100, 3'b010, 1, 2'd1};
    tbl[6] = '{3'b000, 0, 1, 0, 32'h0,    3'b000, 3'b100, 1, 2'd2};
    tbl[7] = '{3'b000, 0, 1, 0, 32'h0,    3'b000, 3'b000, 0, 2'd2};
    tbl[8] = '{3'b000, 0, 0, 0, 32'h0,    3'b000, 3'b000, 0, 2'd2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_owner", bus.owner_o, 0);
    chk("rst_mreq", bus.mgr_req_o, 0);
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_rvalid", bus.rvalid_o, 0);
    next_cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drv(tbl[i].req, tbl[i].gnt, tbl[i].rv);
      @(negedge clk);
      chk($sformatf("v%0d_mreq", i), bus.mgr_req_o, tbl[i].e_mreq);
      chk($sformatf("v%0d_addr", i), bus.mgr_addr_o, tbl[i].e_addr);
      chk($sformatf("v%0d_gnt", i), bus.gnt_o, tbl[i].e_gnt);
      chk($sformatf("v%0d_rvalid", i), bus.rvalid_o, tbl[i].e_rv);
      chk($sformatf("v%0d_busy", i), bus.busy_o, tbl[i].e_busy);
      chk($sformatf("v%0d_owner", i), bus.owner_o, tbl[i].e_owner);
      next_cyc();
    end

    // Stalled grant: payload of requester 1 stays put while requester 0 joins
    bus.addr_i[1] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      drv((i == 0) ? 3'b010 : 3'b011, 0, 0);
      @(negedge clk);
      chk($sformatf("lock%0d_addr", i), bus.mgr_addr_o, 32'h100);
      chk($sformatf("lock%0d_gnt", i), bus.gnt_o, 3'b000);
      next_cyc();
    end
    drv(3'b011, 1, 0);
    @(negedge clk);
    chk("lock_gnt1", bus.gnt_o, 3'b010);
    chk("lock_addr_gnt", bus.mgr_addr_o, 32'h100);
    next_cyc();
    drv(3'b001, 1, 1);
    @(negedge clk);
    chk("next_gnt0", bus.gnt_o, 3'b001);
    chk("next_addr0", bus.mgr_addr_o, 32'h1000);
    chk("b2b_rvalid1", bus.rvalid_o, 3'b010);
    next_cyc();

    // Requester 2 write, then error response
    bus.we_i[2] = 1'b1; bus.be_i[2] = 4'hc; bus.wdata_i[2] = 32'hcafe0002;
    drv(3'b100, 1, 1);
    @(negedge clk);
    chk("wr_gnt2", bus.gnt_o, 3'b100);
    chk("wr_we", bus.mgr_we_o, 1);
    chk("wr_be", bus.mgr_be_o, 4'hc);
    chk("wr_wdata", bus.mgr_wdata_o, 32'hcafe0002);
    next_cyc();
    drv(3'b000, 0, 1);
    bus.mgr_err_i = 1'b1; bus.mgr_rdata_i = 32'hdeadbeef;
    @(negedge clk);
    chk("err_rvalid", bus.rvalid_o, 3'b100);
    chk("err_err", bus.err_o, 1);
    chk("err_rdata", bus.rdata_o, 32'hdeadbeef);
    next_cyc();
    bus.mgr_err_i = 1'b0;
    chk("err_busy", bus.busy_o, 0);

    // Response to owner 0 together with handshake for requester 1
    drv(3'b001, 1, 0);
    next_cyc();
    chk("own0_owner", bus.owner_o, 0);
    drv(3'b010, 1, 1);
    @(negedge clk);
    chk("swap_rvalid", bus.rvalid_o, 3'b001);
    chk("swap_gnt", bus.gnt_o, 3'b010);
    next_cyc();
    chk("swap_owner", bus.owner_o, 1);
    chk("swap_busy", bus.busy_o, 1);

    // Locked requester withdraws before grant
    drv(3'b000, 0, 1);
    next_cyc();
    drv(3'b100, 0, 0);
    next_cyc();
    drv(3'b001, 1, 0);
    @(negedge clk);
    chk("drop_mreq", bus.mgr_req_o, 0);
    chk("drop_gnt", bus.gnt_o, 3'b000);
    next_cyc();
    @(negedge clk);
    chk("drop_next_gnt", bus.gnt_o, 3'b001);
    next_cyc();

    // Reset while outstanding: no response leaks, pointer back to 0
    drv(3'b000, 0, 1);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_busy", bus.busy_o, 0);
    chk("rst_mid_rvalid", bus.rvalid_o, 3'b000);
    chk("rst_mid_owner", bus.owner_o, 0);
    next_cyc();
    rst_n = 1'b1;
    drv(3'b111, 1, 0);
    @(negedge clk);
    chk("rst_rr_gnt", bus.gnt_o, 3'b001);
    next_cyc();

    // Randomized run against the reference model
    rst_n = 1'b0;
    drv(3'b000, 0, 0);
    next_cyc();
    rst_n = 1'b1;
    m_busy = 0; m_owner = 0; m_rr = 0; m_lock = 0; m_lk = 0;
    for (int n = 0; n < 400; n++) begin
      drv(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.mgr_rdata_i = $urandom();
      bus.mgr_err_i   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
        bus.addr_i[i]  = $urandom();
        bus.wdata_i[i] = $urandom();
        bus.we_i[i]    = 1'($urandom_range(0, 1));
        bus.be_i[i]    = 4'($urandom_range(0, 15));
      end
      m_elig = !m_busy || bus.mgr_rvalid_i;
      m_any  = 0;
      cnd    = 0;
      if (m_lock) begin
        cnd = m_lk; m_any = bus.req_i[m_lk];
      end else begin
        for (int k = 0; k < 3; k++)
          if (!m_any && bus.req_i[(m_rr + k) % 3]) begin m_any = 1; cnd = (m_rr + k) % 3; end
      end
      m_mreq = m_elig && m_any;
      e_gnt = '0; e_rv = '0;
      if (m_mreq && bus.mgr_gnt_i) e_gnt[cnd] = 1'b1;
      if (m_busy && bus.mgr_rvalid_i) e_rv[m_owner] = 1'b1;
      @(negedge clk);
      chk("r_mreq", bus.mgr_req_o, m_mreq);
      chk("r_addr", bus.mgr_addr_o, m_mreq ? bus.addr_i[cnd] : 32'h0);
      chk("r_we", bus.mgr_we_o, m_mreq ? bus.we_i[cnd] : 1'b0);
      chk("r_be", bus.mgr_be_o, m_mreq ? bus.be_i[cnd] : 4'h0);
      chk("r_wdata", bus.mgr_wdata_o, m_mreq ? bus.wdata_i[cnd] : 32'h0);
      chk("r_gnt", bus.gnt_o, e_gnt);
      chk("r_rvalid", bus.rvalid_o, e_rv);
      chk("r_rdata", bus.rdata_o, m_busy ? bus.mgr_rdata_i : 32'h0);
      chk("r_err", bus.err_o, m_busy ? bus.mgr_err_i : 1'b0);
      chk("r_busy", bus.busy_o, m_busy);
      chk("r_owner", bus.owner_o, m_owner[1:0]);
      if (m_mreq && bus.mgr_gnt_i) begin
        m_lock = 0; m_owner = cnd; m_rr = (cnd + 1) % 3; m_busy = 1;
      end else begin
        if (m_mreq) begin m_lock = 1; m_lk = cnd; end
        else if (m_lock && !bus.req_i[m_lk]) m_lock = 0;
        if (m_busy && bus.mgr_rvalid_i) m_busy = 0;
      end
      next_cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zeroheti_obi_arb.md
ZEROHETI_OBI_ARB -- requirements
Module: zeroheti_obi_arb

Interface
REQ-001 The block SHALL have parameter NumReq, default 3, the number of OBI requesters (2..8).
REQ-002 The block SHALL have parameter IdxW, default $clog2(NumReq), the requester index width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req_i, input, NumReq, per-requester OBI request.
REQ-006 The block SHALL have port addr_i, input, NumReq x 32, per-requester address.
REQ-007 The block SHALL have port we_i, input, NumReq, per-requester write enable.
REQ-008 The block SHALL have port be_i, input, NumReq x 4, per-requester byte enables.
REQ-009 The block SHALL have port wdata_i, input, NumReq x 32, per-requester write data.
REQ-010 The block SHALL have port gnt_o, output, NumReq, per-requester grant.
REQ-011 The block SHALL have port rvalid_o, output, NumReq, per-requester response valid.
REQ-012 The block SHALL have port rdata_o, output, 32, shared response data; err_o, output, 1, shared response error.
REQ-013 The block SHALL have ports mgr_req_o/addr_o/we_o/be_o/wdata_o, outputs (1/32/1/4/32), the request to the shared subordinate.
REQ-014 The block SHALL have ports mgr_gnt_i/rvalid_i/rdata_i/err_i, inputs (1/1/32/1), the subordinate handshake and response.
REQ-015 The block SHALL have port owner_o, output, IdxW, index of the requester owning the outstanding transaction; busy_o, output, 1, asserted while a transaction is outstanding.

Function
REQ-016 The block SHALL implement FSM states IDLE (no outstanding transaction) and OUTST (one outstanding transaction, awaiting mgr_rvalid_i).
REQ-017 The block SHALL have a round-robin pointer rr_q; the winner is the first asserted req_i index at or above rr_q, wrapping modulo NumReq.
REQ-018 The block SHALL be eligible to issue when state==IDLE, or when state==OUTST and mgr_rvalid_i==1 in the same cycle (back-to-back, zero-bubble).
REQ-019 While eligible and any req_i is set, the block SHALL drive mgr_req_o=1 and mgr_addr/we/be/wdata_o from the winner, combinationally (0-cycle request latency).
REQ-020 The block SHALL drive gnt_o[winner]=mgr_gnt_i and all other gnt_o bits to 0.
REQ-021 On a cycle with mgr_req_o=0, the block SHALL drive all mgr_* payload outputs to 0.
REQ-022 When mgr_req_o=1 and mgr_gnt_i=0, the block SHALL set lock_q and hold the winner index in lk_idx_q; while lock_q is set, the winner SHALL be lk_idx_q regardless of other req_i, so the request payload stays stable until grant.
REQ-023 On handshake (mgr_req_o & mgr_gnt_i), the block SHALL clear lock_q, set owner_q=winner, set rr_q=(winner+1) mod NumReq, and enter OUTST.
REQ-024 In OUTST, the block SHALL drive rvalid_o[owner_q]=mgr_rvalid_i, rdata_o=mgr_rdata_i and err_o=mgr_err_i; on mgr_rvalid_i without a new handshake it SHALL return to IDLE.
REQ-025 In OUTST, mgr_rvalid_i with a simultaneous new handshake SHALL deliver the response to the old owner and move owner_q to the new winner, remaining in OUTST.
REQ-026 The block SHALL ignore mgr_rvalid_i in IDLE: rvalid_o stays all-zero and no state changes.
REQ-027 In OUTST, the block SHALL NOT assert mgr_req_o without a same-cycle mgr_rvalid_i; lock_q is retained across such cycles.
REQ-028 If the locked requester deasserts req_i before grant (OBI violation), the block SHALL clear lock_q and drive mgr_req_o=0 that cycle.
REQ-029 The block SHALL drive busy_o=(state==OUTST) and owner_o=owner_q.

Reset
REQ-030 On rst_ni low, the block SHALL asynchronously set state=IDLE, rr_q=0, owner_q=0, lock_q=0 and lk_idx_q=0; all outputs SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding transaction without issuing any rvalid_o pulse.

Verification
REQ-032 The bench SHALL cover: req_i=3'b111 continuous, gnt always 1, rvalid 1 cycle later -> grants in order 0,1,2,0,1,2; one handshake every cycle after the first.
REQ-033 The bench SHALL cover: req_i[1] with addr 0x100, gnt held 0 for 3 cycles while req_i[0] rises -> mgr_addr_o stays 0x100 until gnt; then requester 0 is served next.
REQ-034 The bench SHALL cover: requester 2 write outstanding, rvalid with err=1 -> rvalid_o=3'b100, err_o=1, state returns to IDLE, busy_o=0.
REQ-035 The bench SHALL cover: OUTST owner 0, rvalid and a new gnt for requester 1 in the same cycle -> rvalid_o=3'b001, owner_o=1, busy_o stays 1.
REQ-036 The bench SHALL cover: spurious mgr_rvalid_i in IDLE -> rvalid_o=0, no state change; then rst_ni pulsed in OUTST -> busy_o=0, rr_q=0, no rvalid_o.
